div4_seq: RTL

- Sequential restoring divider for the ALU datapath. It is the inverse counterpart to the add/multiply path: given dividend and divisor, it produces quotient and remainder over WIDTH iterations.
- It sits beside alu4 and uses a start/done handshake so a controller can issue a divide and wait for the result.
- Subtract and compare are built from the team's existing gate-level primitives (inverter, xor, and/or) as a WIDTH+1-bit ripple subtractor.

---
 rtl/div4_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div4_seq.sv
// div4_seq: sequential restoring divider with a start/done handshake.
// Produces an unsigned quotient and remainder over WIDTH iterations. The
// trial subtraction is a WIDTH+1-bit ripple subtractor built from basic gates.
//
// state | meaning
// IDLE  | waiting for start; results from the last divide are held
// RUN   | one restoring shift/subtract step per cycle, busy=1
// FIN   | results registered, done=1 for this single cycle
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    // Restored partial remainder is always below the divisor, so WIDTH bits
    // hold it; the shifted/trial values carry the extra top bit.
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_qreg;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_zero_div;
    logic             w_last;
    logic             w_fits;
    logic [WIDTH:0]   w_psh;
    logic [WIDTH:0]   w_sub_b;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_prem_next;
    logic [WIDTH-1:0] w_qreg_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_zero_div = (divisor == '0);
    assign w_last     = (r_cnt == CNT_W'(1));

    // Shift {partial remainder, quotient register} left by one.
    assign w_psh   = {r_prem, r_qreg[WIDTH-1]};
    assign w_sub_b = ~{1'b0, r_dvsr};
    assign w_c[0]  = 1'b1;

    // Ripple subtractor: a - b = a + ~b + 1, carry-in of 1 at bit 0.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        assign w_diff[i] = w_psh[i] ^ w_sub_b[i] ^ w_c[i];
        if (i < WIDTH) begin : g_carry
            assign w_c[i+1] = (w_psh[i] & w_sub_b[i]) | (w_c[i] & (w_psh[i] ^ w_sub_b[i]));
        end
    end

    // Sign bit clear means the divisor fits into the shifted remainder.
    assign w_fits      = ~w_diff[WIDTH];
    assign w_prem_next = w_fits ? w_diff[WIDTH-1:0] : w_psh[WIDTH-1:0];
    assign w_qreg_next = {r_qreg[WIDTH-2:0], w_fits};

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; divide-by-zero skips the iteration entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_zero_div ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, restoring steps and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_prem <= '0;
            r_qreg <= '0;
            r_dvsr <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (w_zero_div) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_qreg <= dividend;
                r_prem <= '0;
                r_dvsr <= divisor;
                r_cnt  <= CNT_W'(WIDTH);
                r_dbz  <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_prem <= w_prem_next;
            r_qreg <= w_qreg_next;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_quot <= w_qreg_next;
                r_rem  <= w_prem_next;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_FIN);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
